// File: rtl/cic_comp_pkg.sv
// Shared types and constants for the CIC droop-compensation decimating FIR.
package cic_comp_pkg;

  localparam int unsigned NUM_TAPS_DEF = 21;
  localparam int unsigned COEF_W       = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Symmetric taps, Q1.17, summing to 2^17 for unity DC gain
  localparam logic signed [COEF_W-1:0] COEFS [NUM_TAPS_DEF] = '{
    -18'sd200,  18'sd300,   18'sd600,  -18'sd900,  -18'sd1500,
     18'sd1800, 18'sd3200, -18'sd3600, -18'sd7000,  18'sd10000,
     18'sd125672,
     18'sd10000, -18'sd7000, -18'sd3600, 18'sd3200,  18'sd1800,
    -18'sd1500, -18'sd900,   18'sd600,   18'sd300,  -18'sd200
  };

  function automatic int unsigned acc_width(input int unsigned w_in,
                                            input int unsigned w_coef,
                                            input int unsigned taps);
    return w_in + w_coef + $clog2(taps);
  endfunction

endpackage

// File: rtl/cic_comp_sample_buf.sv
// Circular sample history with a single write port and a combinational
// read at (base - k) mod NUM_TAPS.
module cic_comp_sample_buf #(
  parameter int unsigned NUM_TAPS = 21,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PTR_W    = $clog2(NUM_TAPS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] base_i,
  input  logic [PTR_W-1:0] k_i,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [WIDTH-1:0] mem_q [NUM_TAPS];
  logic [PTR_W:0]   rd_idx_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_o <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_ptr_o] <= wr_data_i;
      wr_ptr_o        <= (wr_ptr_o == PTR_W'(NUM_TAPS - 1)) ? '0 : wr_ptr_o + PTR_W'(1);
    end
  end

  // One extra bit so base + NUM_TAPS cannot overflow before the subtract
  always_comb begin
    if (base_i >= k_i) begin
      rd_idx_c = (PTR_W + 1)'(base_i) - (PTR_W + 1)'(k_i);
    end else begin
      rd_idx_c = (PTR_W + 1)'(base_i) + (PTR_W + 1)'(NUM_TAPS) - (PTR_W + 1)'(k_i);
    end
    rd_data_c = mem_q[rd_idx_c[PTR_W-1:0]];
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR, decimating by DEC, one time-shared MAC.
// Define CIC_COMP_SAT_EN to saturate the output instead of wrapping it.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = NUM_TAPS_DEF,
  parameter int unsigned DEC        = 2,
  parameter int unsigned WIDTH_IN   = 16,
  parameter int unsigned WIDTH_OUT  = 16,
  parameter int unsigned WIDTH_COEF = COEF_W,
  parameter int unsigned COEF_FRAC  = 17
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        tick_i,
  input  logic signed [WIDTH_IN-1:0]  signal_i,
  input  logic                        clear_i,
  output logic                        tick_o,
  output logic signed [WIDTH_OUT-1:0] signal_o,
  output logic                        busy_o,
  output logic                        overrun_o
);

  localparam int unsigned PTR_W  = $clog2(NUM_TAPS);
  localparam int unsigned PH_W   = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int unsigned PROD_W = WIDTH_IN + WIDTH_COEF;
  localparam int unsigned ACC_W  = acc_width(WIDTH_IN, WIDTH_COEF, NUM_TAPS);

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W - WIDTH_OUT + 1){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W - WIDTH_OUT + 1){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

  state_t                       state_q;
  logic [PTR_W-1:0]             base_q;
  logic [PTR_W-1:0]             k_q;
  logic [PTR_W-1:0]             wr_ptr;
  logic [PH_W-1:0]              phase_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [WIDTH_IN-1:0]   rd_data;
  logic                         accept_c;
  logic                         start_c;
  logic signed [WIDTH_COEF-1:0] coef_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      shifted_c;
  logic signed [WIDTH_OUT-1:0]  result_c;

  cic_comp_sample_buf #(
    .NUM_TAPS (NUM_TAPS),
    .WIDTH    (WIDTH_IN),
    .PTR_W    (PTR_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (accept_c),
    .wr_data_i (signal_i),
    .base_i    (base_q),
    .k_i       (k_q),
    .wr_ptr_o  (wr_ptr),
    .rd_data_c (rd_data)
  );

  assign accept_c = tick_i && (state_q == IDLE);
  assign start_c  = accept_c && (phase_q == PH_W'(DEC - 1));

  always_comb begin
    coef_c    = WIDTH_COEF'(COEFS[k_q]);
    prod_c    = rd_data * coef_c;
    shifted_c = acc_q >>> COEF_FRAC;
    result_c  = WIDTH_OUT'(shifted_c);
`ifdef CIC_COMP_SAT_EN
    if (shifted_c > OUT_MAX) begin
      result_c = WIDTH_OUT'(OUT_MAX);
    end else if (shifted_c < OUT_MIN) begin
      result_c = WIDTH_OUT'(OUT_MIN);
    end
`endif
  end

  // Control FSM, phase counter and MAC datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      k_q      <= '0;
      phase_q  <= '0;
      acc_q    <= '0;
      tick_o   <= 1'b0;
      signal_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            phase_q <= (phase_q == PH_W'(DEC - 1)) ? '0 : phase_q + PH_W'(1);
            if (start_c) begin
              base_q  <= wr_ptr;
              acc_q   <= '0;
              k_q     <= '0;
              busy_o  <= 1'b1;
              state_q <= MAC;
            end
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod_c);
          k_q   <= k_q + PTR_W'(1);
          if (k_q == PTR_W'(NUM_TAPS - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          signal_o <= result_c;
          tick_o   <= 1'b1;
          busy_o   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as clear_i keeps it set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overrun_o <= 1'b0;
    end else if (tick_i && (state_q != IDLE)) begin
      overrun_o <= 1'b1;
    end else if (clear_i) begin
      overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir with a reference convolution and an
// expected-output queue.
module tb_cic_comp_fir;

  localparam int N   = 21;
  localparam int DEC = 2;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b0;
  logic               tick   = 1'b0;
  logic               clear  = 1'b0;
  logic signed [15:0] sig_in = '0;
  logic               tick_o;
  logic signed [15:0] sig_out;
  logic               busy;
  logic               ovr;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;

  int coef_tb [N] = '{-200, 300, 600, -900, -1500, 1800, 3200, -3600, -7000, 10000,
                      125672,
                      10000, -7000, -3600, 3200, 1800, -1500, -900, 600, 300, -200};

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tick_i    (tick),
    .signal_i  (sig_in),
    .clear_i   (clear),
    .tick_o    (tick_o),
    .signal_o  (sig_out),
    .busy_o    (busy),
    .overrun_o (ovr)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int                 hist [N];
  int                 m_wr;
  int                 m_phase;
  int                 m_busy;
  bit                 m_ovr;
  bit                 m_drop;
  logic signed [15:0] exp_q [$];
  logic signed [15:0] exp_v;

  function automatic logic signed [15:0] model_out(input int base);
    longint acc;
    longint sh;
    acc = 0;
    for (int k = 0; k < N; k++)
      acc += longint'(hist[(base - k + N) % N]) * longint'(coef_tb[k]);
    sh = acc >>> 17;
`ifdef CIC_COMP_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return 16'(sh);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) hist[i] = 0;
      m_wr = 0; m_phase = 0; m_busy = 0; m_ovr = 0;
      exp_q.delete();
    end else begin
      m_drop = tick && (m_busy != 0);
      if (m_busy != 0) m_busy--;
      if (m_drop) m_ovr = 1;
      else if (clear) m_ovr = 0;
      if (tick && !m_drop) begin
        hist[m_wr] = int'(sig_in);
        if (m_phase == DEC - 1) begin
          exp_q.push_back(model_out(m_wr));
          m_busy  = N + 1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
        m_wr = (m_wr + 1) % N;
      end
    end
  end

  // Output monitor: every tick_o must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && tick_o) begin
      n_out++;
      chk("out_expected_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        chk("out_sample", sig_out, exp_v);
      end
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    tick   = 1'b1;
    sig_in = 16'(v);
    @(negedge clk);
    tick   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int lat, busy_cyc, pulses, x;

  initial begin
    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tick_o", tick_o, 0);
    chk("rst_signal_o", sig_out, 0);
    chk("rst_busy_o", busy, 0);
    chk("rst_overrun_o", ovr, 0);
    rst_n = 1'b1;
    n_out = 0;
    repeat (100) @(negedge clk);
    chk("idle_no_tick_o", n_out, 0);

    // DC gain
    n_out = 0;
    for (int i = 0; i < 60; i++) begin
      send(1000);
      repeat (29) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    chk("dc_output_count", n_out, 30);
    chk("dc_last_value", sig_out, 1000);
    chk("dc_no_overrun", ovr, 0);

    // Latency and busy width
    do_reset();
    send(0);
    repeat (29) @(negedge clk);
    send(123);
    lat = -1; busy_cyc = 0; pulses = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) @(negedge clk);
      if (busy) busy_cyc++;
      if (tick_o) begin
        pulses++;
        if (lat < 0) lat = c;
      end
    end
    chk("latency_clocks", lat, 22);
    chk("busy_cycles", busy_cyc, 22);
    chk("tick_o_pulses", pulses, 1);

    // Impulse response
    do_reset();
    send(16384);
    repeat (29) @(negedge clk);
    send(0);
    repeat (29) @(negedge clk);
    chk("impulse_first", sig_out, (16384 * coef_tb[1]) >>> 17);
    for (int i = 0; i < 24; i++) begin
      send(0);
      repeat (29) @(negedge clk);
    end
    chk("impulse_tail_zero", sig_out, 0);

    // Overrun and clear
    do_reset();
    send(5);
    repeat (9) @(negedge clk);
    send(6);
    repeat (9) @(negedge clk);
    chk("ovr_before_drop", ovr, 0);
    send(7);
    chk("ovr_on_drop", ovr, 1);
    repeat (9) @(negedge clk);
    send(8);
    chk("ovr_model", ovr, m_ovr);
    repeat (40) @(negedge clk);
    chk("ovr_sticky", ovr, 1);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    chk("ovr_cleared", ovr, 0);
    send(1);
    repeat (9) @(negedge clk);
    send(2);
    repeat (4) @(negedge clk);
    @(negedge clk); tick = 1'b1; clear = 1'b1; sig_in = 16'(99);
    @(negedge clk); tick = 1'b0; clear = 1'b0;
    chk("ovr_set_beats_clear", ovr, 1);
    repeat (40) @(negedge clk);

    // Full-scale input sign-matched to the taps
    do_reset();
    for (int n = 0; n < 22; n++) begin
      x = (n == 0) ? 0 : ((coef_tb[21 - n] < 0) ? -32767 : 32767);
      send(x);
      repeat (29) @(negedge clk);
    end
    repeat (30) @(negedge clk);
`ifdef CIC_COMP_SAT_EN
    chk("fullscale_saturated", sig_out, 32767);
`else
    chk("fullscale_wrapped", sig_out, -19570);
`endif

    // Reset during MAC
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(20000);
      if (i < 7) repeat (29) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_low", busy, 0);
    chk("abort_tick_o_low", tick_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_out = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_tick_o", n_out, 0);
    send(30000);
    repeat (29) @(negedge clk);
    send(30000);
    repeat (30) @(negedge clk);
    chk("post_abort_count", n_out, 1);
    chk("post_abort_zero_history", sig_out,
        (30000 * coef_tb[0] + 30000 * coef_tb[1]) >>> 17);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
